// File: rtl/regfile_pkg.sv
// Shared constants and reset-value helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_DEPTH  = 32;
  localparam int unsigned DEF_NRD    = 2;

  // Each register resets to its own index; callers zero-extend to the data width.
  function automatic logic [31:0] reset_val(input int unsigned idx);
    return idx;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: address mux over the storage array and the
// busy scoreboard. With REGFILE_MP_BYPASS_EN defined, an in-flight write to
// the same address is merged lane by lane into the returned data.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic [DATA_W-1:0]          regs [DEPTH],
  input  logic [DEPTH-1:0]           busy,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic                       wena,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W/8-1:0]        wsel,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wclr,
  input  logic                       bset,
  input  logic [$clog2(DEPTH)-1:0]   bset_addr,
`endif
  output logic [DATA_W-1:0]          rdata,
  output logic                       rbusy
);

`ifdef REGFILE_MP_BYPASS_EN
  localparam int unsigned NLANE = DATA_W / 8;

  logic hit;

  // Stored value, overridden per lane by a same-cycle write to this address.
  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr];
    hit   = wena && (waddr == raddr) && (waddr != '0);
    if (hit) begin
      for (int unsigned l = 0; l < NLANE; l++) begin
        if (wsel[l]) rdata[8*l +: 8] = wdata[8*l +: 8];
      end
      // A same-address set keeps the register busy, so only a lone clear hides it.
      if (wclr && !(bset && (bset_addr == waddr))) rbusy = 1'b0;
    end
  end
`else
  // Stored state only; writes become visible after the clock edge.
  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr];
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-lane writes and a busy scoreboard.
// Register 0 is hardwired to zero and never marked busy.
// Optional feature: define REGFILE_MP_BYPASS_EN for write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NRD    = DEF_NRD,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned NLANE  = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   raddr,
  output logic [NRD*DATA_W-1:0]   rdata,
  output logic [NRD-1:0]          rbusy,
  input  logic                    wena,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [NLANE-1:0]        wsel,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    wclr,
  input  logic                    bset,
  input  logic [ADDR_W-1:0]       bset_addr,
  output logic [ADDR_W:0]         pend_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              set_hit;
  logic              set_eff;
  logic              clr_eff;

  // Storage: reset to index values, byte-lane writes, address 0 ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(reset_val(i));
    end else if (wena && (waddr != '0)) begin
      for (int unsigned l = 0; l < NLANE; l++) begin
        if (wsel[l]) regs[waddr][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  // Effective set/clear: only actual busy-bit transitions move the counter,
  // and a same-address set suppresses the clear.
  always_comb begin
    set_hit = bset && (bset_addr != '0);
    set_eff = set_hit && !busy[bset_addr];
    clr_eff = wena && wclr && (waddr != '0) && busy[waddr]
              && !(set_hit && (bset_addr == waddr));
  end

  // Scoreboard bits and the pending-producer count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (clr_eff) busy[waddr]     <= 1'b0;
      if (set_eff) busy[bset_addr] <= 1'b1;
      if (set_eff && !clr_eff)      pend_cnt <= pend_cnt + CNT_ONE;
      else if (clr_eff && !set_eff) pend_cnt <= pend_cnt - CNT_ONE;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_rdport (
      .regs      (regs),
      .busy      (busy),
      .raddr     (raddr[k*ADDR_W +: ADDR_W]),
`ifdef REGFILE_MP_BYPASS_EN
      .wena      (wena),
      .waddr     (waddr),
      .wsel      (wsel),
      .wdata     (wdata),
      .wclr      (wclr),
      .bset      (bset),
      .bset_addr (bset_addr),
`endif
      .rdata     (rdata[k*DATA_W +: DATA_W]),
      .rbusy     (rbusy[k])
    );
  end

endmodule
